router_fifo: RTL and testbench

ROUTER_FIFO -- requirements
Module: router_fifo

---
 rtl/router_fifo.sv | 86 ++++++++
 tb/tb_router_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-port router FIFO: stores {lfd_state, data} entries and tracks the outgoing packet's remaining byte count.
// Optional sticky over/underflow flag is enabled by defining ROUTER_FIFO_OVF_EN.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_rst,
  input  logic             w_enb,
  input  logic             r_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_active,
  output logic             ovf_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [6:0]     pkt_cnt;
  logic [WIDTH:0] rd_data;
  logic           rst_any;
  logic           wr_fire;
  logic           rd_fire;

  assign rst_any = rst || s_rst;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_fire = w_enb && !full;
  assign rd_fire = r_enb && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign pkt_active = (pkt_cnt != 7'd0);

  // Storage is deliberately never reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst_any && wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, d_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= 7'd0;
      d_out   <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
        d_out  <= rd_data[WIDTH-1:0];
        // Header length field counts payload bytes; +1 covers the trailing parity byte.
        if (rd_data[WIDTH]) begin
          pkt_cnt <= {1'b0, rd_data[7:2]} + 7'd1;
        end else if (pkt_cnt != 7'd0) begin
          pkt_cnt <= pkt_cnt - 7'd1;
        end
      end
    end
  end

`ifdef ROUTER_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst_any) begin
      ovf_q <= 1'b0;
    end else if ((w_enb && full) || (r_enb && empty)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo; expected values are hand-computed per step.
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_rst = 1'b0;
  logic       w_enb = 1'b0;
  logic       r_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       full;
  logic       empty;
  logic       pkt_active;
  logic       ovf_err;

  int checks = 0;
  int errors = 0;

`ifdef ROUTER_FIFO_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_rst      (s_rst),
    .w_enb      (w_enb),
    .r_enb      (r_enb),
    .lfd_state  (lfd_state),
    .d_in       (d_in),
    .d_out      (d_out),
    .full       (full),
    .empty      (empty),
    .pkt_active (pkt_active),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wr(input logic lfd, input logic [7:0] d);
    w_enb = 1'b1; lfd_state = lfd; d_in = d;
    step();
    w_enb = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic rd();
    r_enb = 1'b1;
    step();
    r_enb = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(d_out), 32'h00);
    check("rst_pkt", 32'(pkt_active), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);

    // Packet: header 0x0C (3 payload bytes) + parity
    wr(1'b1, 8'h0C);
    check("hdr_not_empty", 32'(empty), 32'd0);
    wr(1'b0, 8'h11);
    wr(1'b0, 8'h22);
    wr(1'b0, 8'h33);
    wr(1'b0, 8'h44);
    rd();
    check("pkt_hdr", 32'(d_out), 32'h0C);
    check("pkt_active_hdr", 32'(pkt_active), 32'd1);
    rd();
    check("pkt_p1", 32'(d_out), 32'h11);
    rd();
    check("pkt_p2", 32'(d_out), 32'h22);
    rd();
    check("pkt_p3", 32'(d_out), 32'h33);
    check("pkt_active_p3", 32'(pkt_active), 32'd1);
    rd();
    check("pkt_parity", 32'(d_out), 32'h44);
    check("pkt_active_end", 32'(pkt_active), 32'd0);
    check("pkt_empty", 32'(empty), 32'd1);
    step();
    check("dout_hold", 32'(d_out), 32'h44);

    // Read while empty: no data movement, optional sticky flag
    rd();
    check("rd_empty_dout", 32'(d_out), 32'h44);
    check("rd_empty_still", 32'(empty), 32'd1);
    check("ovf_underflow", 32'(ovf_err), 32'(OVF_ON));
    step();
    check("ovf_sticky", 32'(ovf_err), 32'(OVF_ON));
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    check("srst_ovf", 32'(ovf_err), 32'd0);
    check("srst_dout", 32'(d_out), 32'h00);

    // Fill to full
    for (int i = 1; i <= 16; i++) begin
      wr(1'b0, 8'(i));
      if (i == 15) check("full_at_15", 32'(full), 32'd0);
    end
    check("full_at_16", 32'(full), 32'd1);
    wr(1'b0, 8'h99);
    check("full_after_17", 32'(full), 32'd1);
    check("ovf_overflow", 32'(ovf_err), 32'(OVF_ON));

    // Simultaneous read+write while full: read only
    w_enb = 1'b1; r_enb = 1'b1; d_in = 8'hAA;
    step();
    w_enb = 1'b0; r_enb = 1'b0;
    check("full_rw_dout", 32'(d_out), 32'd1);
    check("full_rw_full", 32'(full), 32'd0);
    for (int i = 2; i <= 16; i++) begin
      rd();
      check($sformatf("drain_%0d", i), 32'(d_out), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_pkt", 32'(pkt_active), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_ovf", 32'(ovf_err), 32'd0);

    // Mid-packet soft reset with a concurrent write
    wr(1'b1, 8'h08);
    wr(1'b0, 8'h55);
    wr(1'b0, 8'h66);
    rd();
    check("mid_hdr", 32'(d_out), 32'h08);
    check("mid_pkt_active", 32'(pkt_active), 32'd1);
    s_rst = 1'b1; w_enb = 1'b1; d_in = 8'h77;
    step();
    s_rst = 1'b0; w_enb = 1'b0;
    check("srst_empty", 32'(empty), 32'd1);
    check("srst_pkt", 32'(pkt_active), 32'd0);
    check("srst_dout2", 32'(d_out), 32'h00);
    step();
    check("srst_write_dropped", 32'(empty), 32'd1);

    // Read+write on empty: write lands, read blocked
    w_enb = 1'b1; r_enb = 1'b1; d_in = 8'h3C;
    step();
    check("rw_empty_dout", 32'(d_out), 32'h00);
    check("rw_empty_flag", 32'(empty), 32'd0);
    // Read+write with one entry: occupancy unchanged
    d_in = 8'h5A;
    step();
    w_enb = 1'b0; r_enb = 1'b0;
    check("rw_one_dout", 32'(d_out), 32'h3C);
    check("rw_one_empty", 32'(empty), 32'd0);
    rd();
    check("rw_last", 32'(d_out), 32'h5A);
    check("rw_last_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
